counter_cmd_arbiter: RTL and testbench

//  Shared-resource scheduler for the 16-bit display counter that feeds fnd_4digit_cntr.

---
 rtl/counter_cmd_arbiter_if.sv | 23 ++
 rtl/counter_cmd_arbiter.sv | 139 +++++++++++++
 tb/tb_counter_cmd_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/counter_cmd_arbiter_if.sv
// Command/display bundle between the button/keypad front end and counter_cmd_arbiter.
// master drives command pulses and observes the counter; slave is the arbiter itself.
interface counter_cmd_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [3:0]       btn_pe;
  logic             key_pe;
  logic [3:0]       key_value;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] disp_value;
  logic             entry_mode;
  logic [4:0]       grant;

  modport master (
    output btn_pe, key_pe, key_value,
    input  value, disp_value, entry_mode, grant
  );

  modport slave (
    input  btn_pe, key_pe, key_value,
    output value, disp_value, entry_mode, grant
  );
endinterface

// File: rtl/counter_cmd_arbiter.sv
// Round-robin scheduler of button/keypad commands onto a shared display counter, with a
// keypad hex-entry FSM. Define SATURATE_EN to make up/down saturate instead of wrapping.
module counter_cmd_arbiter #(
  parameter int WIDTH       = 16,
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic                 clk,
  input  logic                 reset_p,
  counter_cmd_arbiter_if.slave bus
);

  typedef enum logic {S_IDLE, S_ENTRY} state_e;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_COMMIT = 4'hE;
  localparam logic [3:0] KEY_CANCEL = 4'hF;
  localparam int         TW         = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_e           state_q, state_d;
  logic [4:0]       pending_q, pending_d;
  logic [4:0]       grant_q, grant_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [3:0]       key_hold_q, key_hold_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  logic       gnt_vld;
  logic [2:0] gnt_idx;
  logic [3:0] cand;
  logic       btn_gnt, key_gnt, tmo_hit;

  // Round-robin search upward from rr_ptr, modulo the five sources.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    gnt_vld = 1'b0;
    gnt_idx = 3'd0;
    cand    = 4'd0;
    for (int k = 0; k < 5; k++) begin
      cand = {1'b0, rr_ptr_q} + 4'(k);
      if (cand >= 4'd5) cand = cand - 4'd5;
      if (!gnt_vld && pending_q[cand[2:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[2:0];
      end
    end
  end

  assign grant_d    = gnt_vld ? (5'd1 << gnt_idx) : 5'd0;
  assign rr_ptr_d   = !gnt_vld ? rr_ptr_q : ((gnt_idx == 3'd4) ? 3'd0 : gnt_idx + 3'd1);
  assign pending_d  = (pending_q & ~grant_d) | {bus.key_pe, bus.btn_pe};
  assign key_hold_d = bus.key_pe ? bus.key_value : key_hold_q;
  assign btn_gnt    = gnt_vld && (gnt_idx != 3'd4);
  assign key_gnt    = gnt_vld && (gnt_idx == 3'd4);
  assign tmo_hit    = (tmo_q == TW'(TIMEOUT_CYC - 1));

  // FSM state register
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state; a keypad grant takes precedence over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (key_gnt && key_hold_q == KEY_ENTER) state_d = S_ENTRY;
      S_ENTRY: begin
        if (key_gnt) begin
          if (key_hold_q == KEY_COMMIT || key_hold_q == KEY_CANCEL) state_d = S_IDLE;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.entry_mode = (state_q == S_ENTRY);
    bus.disp_value = (state_q == S_ENTRY) ? shadow_q : value_q;
    bus.value      = value_q;
    bus.grant      = grant_q;
  end

  // Command effects of the granted source
  always_comb begin
    value_d  = value_q;
    shadow_d = shadow_q;
    tmo_d    = '0;
    if (state_q == S_IDLE) begin
      if (btn_gnt) begin
        case (gnt_idx)
`ifdef SATURATE_EN
          3'd0:    if (value_q != '1) value_d = value_q + 1'b1;
          3'd1:    if (value_q != '0) value_d = value_q - 1'b1;
`else
          3'd0:    value_d = value_q + 1'b1;
          3'd1:    value_d = value_q - 1'b1;
`endif
          3'd2:    value_d = {value_q[WIDTH-2:0], value_q[WIDTH-1]};
          default: value_d = {value_q[0], value_q[WIDTH-1:1]};
        endcase
      end else if (key_gnt && key_hold_q == KEY_ENTER) begin
        shadow_d = '0;
      end
    end else begin
      if (key_gnt) begin
        if (key_hold_q <= 4'd9)            shadow_d = {shadow_q[WIDTH-5:0], key_hold_q};
        else if (key_hold_q == KEY_COMMIT) value_d  = shadow_q;
      end else if (!tmo_hit) begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      pending_q  <= '0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      key_hold_q <= '0;
      value_q    <= '0;
      shadow_q   <= '0;
      tmo_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pending_q  <= pending_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      key_hold_q <= key_hold_d;
      value_q    <= value_d;
      shadow_q   <= shadow_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Directed bench for counter_cmd_arbiter: reset, up/down wrap, round-robin order,
// rotations, pending merge, keypad entry/commit/cancel/timeout and reset mid-entry.
module tb_counter_cmd_arbiter;

  localparam int W   = 16;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic reset_p;
  int   vectors = 0;
  int   miscompares = 0;

  counter_cmd_arbiter_if #(.WIDTH(W)) bus ();

  counter_cmd_arbiter #(.WIDTH(W), .TIMEOUT_CYC(TMO)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Drive inputs for exactly one rising edge; returns at the following falling edge.
  task automatic drive(input logic [3:0] b, input logic kp, input logic [3:0] kv);
    bus.btn_pe = b; bus.key_pe = kp; bus.key_value = kv;
    @(negedge clk);
    bus.btn_pe = 4'h0; bus.key_pe = 1'b0; bus.key_value = 4'h0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Keypad press followed by its grant edge.
  task automatic press(input logic [3:0] k);
    drive(4'h0, 1'b1, k);
    step();
  endtask

  task automatic test_reset();
    vectors++; if (bus.value !== 16'h0) begin miscompares++; $display("FAIL rst_value got %h want 0000", bus.value); end
    vectors++; if (bus.disp_value !== 16'h0) begin miscompares++; $display("FAIL rst_disp got %h want 0000", bus.disp_value); end
    vectors++; if (bus.entry_mode !== 1'b0) begin miscompares++; $display("FAIL rst_entry got %b want 0", bus.entry_mode); end
    vectors++; if (bus.grant !== 5'h0) begin miscompares++; $display("FAIL rst_grant got %b want 00000", bus.grant); end
    reset_p = 1'b0;
    step();
    vectors++; if (bus.grant !== 5'h0 || bus.value !== 16'h0) begin miscompares++; $display("FAIL post_rst got grant=%b value=%h want 00000/0000", bus.grant, bus.value); end
  endtask

  task automatic test_up();
    for (int i = 1; i <= 3; i++) begin
      drive(4'b0001, 1'b0, 4'h0);
      vectors++; if (bus.grant !== 5'h0) begin miscompares++; $display("FAIL up_latency%0d got %b want 00000", i, bus.grant); end
      step();
      vectors++; if (bus.grant !== 5'b00001) begin miscompares++; $display("FAIL up_grant%0d got %b want 00001", i, bus.grant); end
      vectors++; if (bus.value !== 16'(i)) begin miscompares++; $display("FAIL up_value%0d got %h want %h", i, bus.value, 16'(i)); end
    end
  endtask

  task automatic test_down();
    logic [15:0] exp_wrap;
    for (int i = 2; i >= 0; i--) begin
      drive(4'b0010, 1'b0, 4'h0);
      step();
      vectors++; if (bus.grant !== 5'b00010 || bus.value !== 16'(i)) begin miscompares++; $display("FAIL down%0d got grant=%b value=%h want 00010/%h", i, bus.grant, bus.value, 16'(i)); end
    end
`ifdef SATURATE_EN
    exp_wrap = 16'h0000;
`else
    exp_wrap = 16'hFFFF;
`endif
    drive(4'b0010, 1'b0, 4'h0);
    step();
    vectors++; if (bus.grant !== 5'b00010) begin miscompares++; $display("FAIL down_zero_grant got %b want 00010", bus.grant); end
    vectors++; if (bus.value !== exp_wrap) begin miscompares++; $display("FAIL down_zero_value got %h want %h", bus.value, exp_wrap); end
`ifndef SATURATE_EN
    drive(4'b0001, 1'b0, 4'h0);
    step();
    vectors++; if (bus.value !== 16'h0000) begin miscompares++; $display("FAIL up_wrap got %h want 0000", bus.value); end
`endif
    // Idle-state key other than A: granted, no effect, pointer returns to 0.
    press(4'h5);
    vectors++; if (bus.grant !== 5'b10000 || bus.value !== 16'h0 || bus.entry_mode !== 1'b0) begin miscompares++; $display("FAIL idle_key got grant=%b value=%h entry=%b want 10000/0000/0", bus.grant, bus.value, bus.entry_mode); end
  endtask

  task automatic test_all_at_once();
    logic [15:0] exp_val [5];
    exp_val = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    drive(4'hF, 1'b1, 4'h5);
    vectors++; if (bus.grant !== 5'h0) begin miscompares++; $display("FAIL all_latency got %b want 00000", bus.grant); end
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++; if (bus.grant !== (5'd1 << k)) begin miscompares++; $display("FAIL all_grant%0d got %b want %b", k, bus.grant, 5'd1 << k); end
      vectors++; if (bus.value !== exp_val[k]) begin miscompares++; $display("FAIL all_value%0d got %h want %h", k, bus.value, exp_val[k]); end
    end
    step();
    vectors++; if (bus.grant !== 5'h0) begin miscompares++; $display("FAIL all_drain got %b want 00000", bus.grant); end
  endtask

  task automatic test_rotate();
    logic [3:0]  btn [4];
    logic [15:0] exp_val [4];
    btn     = '{4'b0001, 4'b1000, 4'b0100, 4'b0100};
    exp_val = '{16'h0001, 16'h8000, 16'h0001, 16'h0002};
    for (int i = 0; i < 4; i++) begin
      drive(btn[i], 1'b0, 4'h0);
      step();
      vectors++; if (bus.grant !== {1'b0, btn[i]} || bus.value !== exp_val[i]) begin miscompares++; $display("FAIL rot%0d got grant=%b value=%h want %b/%h", i, bus.grant, bus.value, {1'b0, btn[i]}, exp_val[i]); end
    end
  endtask

  // rr_ptr is 3 here: the search wraps past 3,4 to 0; a repeat down pulse merges.
  task automatic test_back_to_back();
    drive(4'b0011, 1'b0, 4'h0);
    drive(4'b0010, 1'b0, 4'h0);
    vectors++; if (bus.grant !== 5'b00001 || bus.value !== 16'h0003) begin miscompares++; $display("FAIL b2b_first got grant=%b value=%h want 00001/0003", bus.grant, bus.value); end
    step();
    vectors++; if (bus.grant !== 5'b00010 || bus.value !== 16'h0002) begin miscompares++; $display("FAIL b2b_second got grant=%b value=%h want 00010/0002", bus.grant, bus.value); end
    step();
    vectors++; if (bus.grant !== 5'h0 || bus.value !== 16'h0002) begin miscompares++; $display("FAIL b2b_merge got grant=%b value=%h want 00000/0002", bus.grant, bus.value); end
  endtask

  task automatic test_entry();
    logic [3:0]  digits [5];
    logic [15:0] exp_disp [5];
    digits   = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    exp_disp = '{16'h0001, 16'h0012, 16'h0123, 16'h1234, 16'h2345};
    press(4'hA);
    vectors++; if (bus.entry_mode !== 1'b1 || bus.disp_value !== 16'h0) begin miscompares++; $display("FAIL entry_on got entry=%b disp=%h want 1/0000", bus.entry_mode, bus.disp_value); end
    for (int i = 0; i < 5; i++) begin
      press(digits[i]);
      vectors++; if (bus.disp_value !== exp_disp[i]) begin miscompares++; $display("FAIL entry_digit%0d got %h want %h", i, bus.disp_value, exp_disp[i]); end
    end
    vectors++; if (bus.value !== 16'h0002) begin miscompares++; $display("FAIL entry_value_held got %h want 0002", bus.value); end
    press(4'hE);
    vectors++; if (bus.value !== 16'h2345 || bus.entry_mode !== 1'b0 || bus.disp_value !== 16'h2345) begin miscompares++; $display("FAIL commit got value=%h entry=%b disp=%h want 2345/0/2345", bus.value, bus.entry_mode, bus.disp_value); end
    press(4'hA);
    press(4'hE);
    vectors++; if (bus.value !== 16'h0 || bus.entry_mode !== 1'b0) begin miscompares++; $display("FAIL commit_empty got value=%h entry=%b want 0000/0", bus.value, bus.entry_mode); end
  endtask

  task automatic test_cancel_timeout();
    press(4'hA);
    press(4'h7);
    press(4'hB);
    vectors++; if (bus.disp_value !== 16'h0007) begin miscompares++; $display("FAIL key_b_ignored got %h want 0007", bus.disp_value); end
    drive(4'b0001, 1'b0, 4'h0);
    step();
    vectors++; if (bus.grant !== 5'b00001 || bus.value !== 16'h0 || bus.entry_mode !== 1'b1) begin miscompares++; $display("FAIL btn_in_entry got grant=%b value=%h entry=%b want 00001/0000/1", bus.grant, bus.value, bus.entry_mode); end
    press(4'hF);
    vectors++; if (bus.entry_mode !== 1'b0 || bus.value !== 16'h0 || bus.disp_value !== 16'h0) begin miscompares++; $display("FAIL cancel got entry=%b value=%h disp=%h want 0/0000/0000", bus.entry_mode, bus.value, bus.disp_value); end
    press(4'hA);
    press(4'h7);
    repeat (TMO - 1) step();
    vectors++; if (bus.entry_mode !== 1'b1) begin miscompares++; $display("FAIL tmo_early got entry=%b want 1", bus.entry_mode); end
    step();
    vectors++; if (bus.entry_mode !== 1'b0 || bus.value !== 16'h0 || bus.disp_value !== 16'h0) begin miscompares++; $display("FAIL tmo_cancel got entry=%b value=%h disp=%h want 0/0000/0000", bus.entry_mode, bus.value, bus.disp_value); end
  endtask

  task automatic test_reset_mid_entry();
    drive(4'b0001, 1'b0, 4'h0);
    step();
    vectors++; if (bus.value !== 16'h0001) begin miscompares++; $display("FAIL pre_reset_value got %h want 0001", bus.value); end
    press(4'hA);
    press(4'h9);
    vectors++; if (bus.entry_mode !== 1'b1 || bus.disp_value !== 16'h0009) begin miscompares++; $display("FAIL pre_reset_entry got entry=%b disp=%h want 1/0009", bus.entry_mode, bus.disp_value); end
    drive(4'b0001, 1'b0, 4'h0);
    reset_p = 1'b1;
    #1;
    vectors++; if (bus.entry_mode !== 1'b0 || bus.value !== 16'h0 || bus.grant !== 5'h0) begin miscompares++; $display("FAIL mid_reset got entry=%b value=%h grant=%b want 0/0000/00000", bus.entry_mode, bus.value, bus.grant); end
    @(negedge clk);
    reset_p = 1'b0;
    step();
    vectors++; if (bus.entry_mode !== 1'b0 || bus.value !== 16'h0 || bus.grant !== 5'h0) begin miscompares++; $display("FAIL after_reset got entry=%b value=%h grant=%b want 0/0000/00000", bus.entry_mode, bus.value, bus.grant); end
  endtask

  initial begin
    reset_p = 1'b1;
    bus.btn_pe = 4'h0; bus.key_pe = 1'b0; bus.key_value = 4'h0;
    repeat (2) @(negedge clk);
    test_reset();
    test_up();
    test_down();
    test_all_at_once();
    test_rotate();
    test_back_to_back();
    test_entry();
    test_cancel_timeout();
    test_reset_mid_entry();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
